// File: rtl/reservoir_level_ctrl.sv
// reservoir_level_ctrl
//   Tracks reservoir water level from N thermometer-coded level sensors and
//   drives the flow-valve enables. Sensor samples must be stable for DEB
//   preceding edges before the tracked level may step (one step per edge).
//
// Ports
//   clk         rising-edge clock
//   aresetn     asynchronous active-low reset (release synchronised by parent)
//   s[N]        level sensors, s[0] lowest, 1 = water above that sensor
//   fr[N]       flow-valve enables, fr[i] open iff i < N-level
//   dfr         delta-flow valve enable
//   level[LW]   tracked level 0..N
//   sensor_err  pulses the cycle after a non-thermometer sensor code
//
// Direction state
//   state    | meaning
//   DIR_UP   | last level move was an increment
//   DIR_DOWN | last level move was a decrement (also the reset state)
module reservoir_level_ctrl #(
    parameter int N   = 3,
    parameter int DEB = 2,
    localparam int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic [N-1:0]  s,
    output logic [N-1:0]  fr,
    output logic          dfr,
    output logic [LW-1:0] level,
    output logic          sensor_err
);

    // Run counter only needs to reach DEB; keep at least one bit for DEB=0.
    localparam int CW = (DEB < 1) ? 1 : $clog2(DEB + 1);
    localparam logic [CW-1:0] DEB_C = CW'(DEB);
    localparam logic [LW-1:0] N_C   = LW'(N);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t          dir_q;
    dir_t          dir_d;
    logic [LW-1:0] level_d;
    logic [N-1:0]  s_prev;
    logic [CW-1:0] run_q;       // length of identical-sample run ending at s_prev
    logic [CW-1:0] run_d;
    logic [CW-1:0] match_cnt;   // preceding samples equal to the current one
    logic [N:0]    s_ext;
    logic          legal;
    logic          qual;
    logic [LW-1:0] target;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            dir_q      <= DIR_DOWN;
            level      <= '0;
            sensor_err <= 1'b0;
            s_prev     <= '0;
            run_q      <= '0;
        end else begin
            dir_q      <= dir_d;
            level      <= level_d;
            sensor_err <= ~legal;
            s_prev     <= s;
            run_q      <= run_d;
        end
    end

    always_comb begin
        s_ext     = {1'b0, s};
        // A thermometer code plus one is a power of two, so it shares no bits.
        legal     = ((s_ext & (s_ext + 1'b1)) == '0);
        target    = '0;
        for (int i = 0; i < N; i++) begin
            target = target + LW'(s[i]);
        end

        // run_q is zero straight after reset, so history since release counts too.
        match_cnt = (s == s_prev) ? run_q : '0;
        qual      = legal && (match_cnt >= DEB_C);

        if (!legal) begin
            run_d = '0;
        end else if (match_cnt >= DEB_C) begin
            run_d = DEB_C;
        end else begin
            run_d = match_cnt + 1'b1;
        end

        dir_d   = dir_q;
        level_d = level;
        if (qual && (target > level)) begin
            level_d = level + 1'b1;
            dir_d   = DIR_UP;
        end else if (qual && (target < level)) begin
            level_d = level - 1'b1;
            dir_d   = DIR_DOWN;
        end

        fr = '0;
        for (int i = 0; i < N; i++) begin
            fr[i] = ((i + int'(level)) < N);
        end

        if (level == '0) begin
            dfr = 1'b1;
        end else if (level == N_C) begin
            dfr = 1'b0;
        end else begin
            dfr = (dir_q == DIR_DOWN);
        end
    end

endmodule

// File: tb/tb_reservoir_level_ctrl.sv
module tb_reservoir_level_ctrl;

    localparam int N   = 3;
    localparam int DEB = 2;

    logic       clk     = 1'b0;
    logic       aresetn = 1'b0;
    logic [2:0] s       = 3'b000;
    logic [2:0] s0      = 3'b000;
    logic [2:0] fr, fr0;
    logic       dfr, dfr0, err, err0;
    logic [1:0] lvl, lvl0;

    always #5 clk = ~clk;

    reservoir_level_ctrl #(.N(N), .DEB(DEB)) dut (
        .clk(clk), .aresetn(aresetn), .s(s),
        .fr(fr), .dfr(dfr), .level(lvl), .sensor_err(err)
    );

    // DEB=0 instance compared against the legacy fixed 3-sensor behaviour.
    reservoir_level_ctrl #(.N(3), .DEB(0)) dut_leg (
        .clk(clk), .aresetn(aresetn), .s(s0),
        .fr(fr0), .dfr(dfr0), .level(lvl0), .sensor_err(err0)
    );

    typedef struct {
        int lvl;
        int fr;
        int dfr;
        int err;
    } exp_t;

    typedef struct {
        int lvl;
        int fr;
        int dfr;
    } leg_t;

    exp_t q_main[$];
    leg_t q_leg[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference state
    int m_lvl = 0;
    int m_dir = 1;
    int m_err = 0;
    int m_hist[$];
    int l_lvl = 0;
    int l_dir = 1;
    int walk  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Target level of a sensor code, or -1 when it is not a thermometer code.
    function automatic int code_target(input int sv);
        for (int t = 0; t <= N; t++) begin
            if (sv == (1 << t) - 1) return t;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_lvl = 0;
        m_dir = 1;
        m_err = 0;
        m_hist.delete();
        l_lvl = 0;
        l_dir = 1;
        walk  = 0;
    endtask

    task automatic model_edge(input int sv, input int sv0);
        int t;
        int t0;
        bit q;
        t = code_target(sv);
        q = (t >= 0) && (m_hist.size() >= DEB);
        foreach (m_hist[i]) if (m_hist[i] != sv) q = 0;
        if (q && t > m_lvl) begin
            m_lvl++;
            m_dir = 0;
        end else if (q && t < m_lvl) begin
            m_lvl--;
            m_dir = 1;
        end
        m_err = (t < 0) ? 1 : 0;
        if (t < 0) m_hist.delete();
        else begin
            m_hist.push_back(sv);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
        end
        // Legacy block: level follows the sensors directly.
        t0 = code_target(sv0);
        if (t0 > l_lvl) l_dir = 0;
        else if (t0 < l_lvl) l_dir = 1;
        l_lvl = t0;
    endtask

    task automatic push_exp();
        exp_t e;
        leg_t l;
        int   leg_fr[4];
        leg_fr = '{7, 3, 1, 0};
        e.lvl = m_lvl;
        e.fr  = (1 << (N - m_lvl)) - 1;
        e.dfr = (m_lvl == 0) ? 1 : ((m_lvl == N) ? 0 : m_dir);
        e.err = m_err;
        q_main.push_back(e);
        l.lvl = l_lvl;
        l.fr  = leg_fr[l_lvl];
        l.dfr = (l_lvl == 0) ? 1 : ((l_lvl == 3) ? 0 : l_dir);
        q_leg.push_back(l);
    endtask

    task automatic next_walk();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0 && walk > 0) walk--;
        else if (r == 2 && walk < 3) walk++;
    endtask

    task automatic step(input int sv);
        int c0;
        @(negedge clk);
        aresetn = 1'b1;
        next_walk();
        c0 = (1 << walk) - 1;
        s  = sv[2:0];
        s0 = c0[2:0];
        model_edge(sv, c0);
        push_exp();
    endtask

    task automatic hold(input int sv, input int n);
        repeat (n) step(sv);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("async_fr", int'(fr), 7);
        chk("async_dfr", int'(dfr), 1);
        chk("async_level", int'(lvl), 0);
        chk("async_leg_fr", int'(fr0), 7);
        chk("async_leg_dfr", int'(dfr0), 1);
        model_reset();
        s0 = 3'b000;
        push_exp();
    endtask

    // Monitor: every edge is an output event; pop and compare.
    initial begin
        exp_t e;
        leg_t l;
        forever begin
            @(posedge clk);
            #1;
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                chk("level", int'(lvl), e.lvl);
                chk("fr", int'(fr), e.fr);
                chk("dfr", int'(dfr), e.dfr);
                chk("sensor_err", int'(err), e.err);
            end
            if (q_leg.size() > 0) begin
                l = q_leg.pop_front();
                chk("leg_level", int'(lvl0), l.lvl);
                chk("leg_fr", int'(fr0), l.fr);
                chk("leg_dfr", int'(dfr0), l.dfr);
                chk("leg_err", int'(err0), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int sv;
        int n;
        int ill[4];
        ill = '{2, 4, 5, 6};
        #1;
        chk("rst_level", int'(lvl), 0);
        chk("rst_fr", int'(fr), 7);
        chk("rst_dfr", int'(dfr), 1);
        chk("rst_err", int'(err), 0);

        // Idle at empty, then fill one sensor at a time.
        hold(0, 6);
        hold(1, 5);
        hold(3, 5);
        hold(7, 5);
        // Drain with direction, then refill one step.
        hold(3, 5);
        hold(1, 5);
        hold(3, 5);
        // Drain fully, multi-step jump to full, short glitch at full.
        hold(0, 8);
        hold(7, 8);
        hold(0, 2);
        hold(7, 6);
        // Illegal code at level 1 followed by a legal step up.
        hold(1, 8);
        hold(5, 1);
        hold(3, 5);

        reset_pulse();
        hold(7, 3);
        reset_pulse();

        // Random phase: mostly legal codes with varied hold lengths.
        cyc = 0;
        while (cyc < 520) begin
            if ($urandom_range(0, 9) == 0) sv = ill[$urandom_range(0, 3)];
            else sv = (1 << $urandom_range(0, 3)) - 1;
            n = $urandom_range(1, 6);
            hold(sv, n);
            cyc += n;
            if (cyc >= 250 && cyc < 256) reset_pulse();
        end

        repeat (3) @(negedge clk);
        chk("drain_main", q_main.size(), 0);
        chk("drain_leg", q_leg.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reservoir_level_ctrl.md
# reservoir_level_ctrl

Parametrised reservoir water-level controller. It tracks the water level from N thermometer-coded level sensors and drives N supplemental flow-valve enables plus a delta-flow enable. Sensor inputs are debounced by a programmable count, and illegal (non-thermometer) sensor codes are flagged. It is the next generation of our fixed 3-sensor reservoir FSM. With N=3 and DEB=0 its fr/dfr behaviour is cycle-identical to that block, apart from the reset style.

## Interface
- N, default 3, number of level sensors and flow-valve outputs; legal range 2..16
- DEB, default 2, debounce depth: number of preceding identical samples required before the level may move; legal range 0..255
- LW, derived, $clog2(N+1), width of level output
- clk  input  1  rising-edge clock
- aresetn  input  1  reset; asynchronous and active-low
- s  input  N  level sensors; s[0] is the lowest; 1 = water above that sensor
- fr  output  N  flow-valve enables; fr[i] = 1 opens valve i
- dfr  output  1  delta-flow (supplemental) valve enable
- level  output  LW  current tracked level, 0..N
- sensor_err  output  1  1 for the cycle after an illegal sensor code is sampled

## Operation
- Sensor code: s is legal iff s == (1<<T)-1 for some T in 0..N, where T is the target level. Any other pattern is illegal.
- Qualification: a sample at an edge is qualified iff all of the following hold:
  - s is legal;
  - s equals the s sampled at each of the preceding DEB edges;
  - at least DEB edges have occurred since reset release.
  - With DEB=0, every legal sample is qualified.
- Level update at each edge:
  - if qualified and T > level: level <= level+1;
  - if qualified and T < level: level <= level-1;
  - otherwise level holds.
  - The level moves at most one step per cycle, so a multi-level jump in s takes |T-level| cycles after qualification.
  - While s stays stable, qualification persists, so consecutive steps occur on consecutive edges.
- Direction flag dir_down:
  - set to 1 on an edge where level decrements;
  - cleared to 0 on an edge where level increments;
  - held otherwise.
- Outputs, all decoded from registered state only (Moore):
  - fr[i] = 1 iff i < N-level. Level 0 opens all valves; level N opens none.
  - dfr = 1 when level == 0; 0 when level == N; otherwise equals dir_down.
- Errors:
  - sensor_err <= ~legal(s) on every edge.
  - An illegal sample never moves the level and restarts the debounce history; the next DEB samples after it are unqualified.
- Illegal parameter values (N or DEB out of range) are outside scope; no runtime check.

## Timing
- Reset (aresetn low, asynchronous):
  - level=0, dir_down=1, so fr = all ones and dfr=1;
  - sensor_err=0;
  - debounce history cleared.
- Deassertion is synchronised by the parent; the first edge with aresetn high counts as edge 0 since release.
- Latency:
  - s changes to a new legal value sampled first at edge k and is held; the first level step occurs at edge k+DEB.
  - fr, dfr and level reflect that step in the cycle following edge k+DEB.
- Glitch: a change shorter than DEB+1 samples produces no level movement. Returning to the original value also restarts the history.
- Level already equal to T: no movement and dir_down unchanged, regardless of qualification.
- Reset mid-debounce or mid-multi-step: all state returns immediately to reset values. Any partially accumulated history is discarded.
- sensor_err is a single-cycle pulse per illegal sample and stays high on consecutive illegal samples. It is independent of DEB.

## Test plan
- Reset, then s=000 held (N=3, DEB=2):
  - level=0, fr=111, dfr=1 throughout;
  - sensor_err=0.
- Rising fill (N=3, DEB=2), s steps 000→001→011→111, each held 5 cycles:
  - each level increment occurs 2 edges after the change;
  - fr goes 111→011→001→000;
  - dfr goes 1→0→0→0.
- Draining with direction (N=3, DEB=2), from level 3 apply s=011, then s=001:
  - level 2: fr=001, dfr=1;
  - level 1: fr=011, dfr=1.
  - Then apply s=011: level 2, dfr=0.
- Multi-step jump and glitch (N=3, DEB=2):
  - From level 0, s=111 held: level reaches 1, 2, 3 on edges k+2, k+3, k+4.
  - A 2-cycle pulse s=000 from level 3: no level change.
- Illegal code (N=3, DEB=2), s=101 for 1 cycle at level 1:
  - sensor_err=1 for exactly 1 cycle;
  - level holds at 1;
  - a following s=011 steps the level at edge +2.
- Legacy equivalence and async reset:
  - N=3, DEB=0, random 500-cycle s sequence: fr/dfr match the legacy 3-sensor model every cycle.
  - Asserting aresetn=0 between clock edges forces fr=111, dfr=1 immediately.
